// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution: latch op, evaluate via shared comparator,
// then present redirect and resolved-op handshakes independently.
module branch_resolve_unit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_pc_i,
  input  logic [31:0] in_imm_i,
  input  logic [31:0] in_rs1_i,
  input  logic [31:0] in_rs2_i,
  input  logic [1:0]  in_op_i,
  input  logic [2:0]  in_funct3_i,
  output logic [31:0] cmp_a_o,
  output logic [31:0] cmp_b_o,
  output logic [2:0]  cmp_fn_o,
  input  logic        cmp_result_i,
  output logic        redirect_valid_o,
  input  logic        redirect_ready_i,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_link_o,
  output logic        out_taken_o,
  output logic        out_exc_o
);
  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP} state_t;

  localparam logic [1:0] OP_BR   = 2'b00;
  localparam logic [1:0] OP_JAL  = 2'b01;
  localparam logic [1:0] OP_JALR = 2'b10;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_imm, r_rs1, r_rs2;
  logic [1:0]  r_op;
  logic [2:0]  r_f3;
  logic        r_taken, r_exc, r_out_done, r_rd_done;
  logic [31:0] r_target, r_link;

  logic [31:0] w_sum_pc, w_sum_rs, w_target;
  logic        w_taken, w_exc, w_out_fire, w_rd_fire, w_both_done;

  assign w_sum_pc = r_pc + r_imm;
  assign w_sum_rs = r_rs1 + r_imm;
  assign w_target = (r_op == OP_JALR) ? {w_sum_rs[31:1], 1'b0} : w_sum_pc;

  always_comb begin
    w_taken = 1'b0;
    case (r_op)
      OP_BR:          w_taken = cmp_result_i;
      OP_JAL, OP_JALR: w_taken = 1'b1;
      default:        w_taken = 1'b0;
    endcase
  end
  assign w_exc = w_taken & w_target[1];

  assign w_out_fire  = out_valid_o & out_ready_i;
  assign w_rd_fire   = redirect_valid_o & redirect_ready_i;
  assign w_both_done = (r_out_done | w_out_fire) & (r_rd_done | w_rd_fire);

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // FSM: next state (flush wins in every state)
  always_comb begin
    w_next = r_state;
    if (flush_i) w_next = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  if (in_valid_i) w_next = S_EVAL;
        S_EVAL:  w_next = S_RESP;
        S_RESP:  if (w_both_done) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // FSM: outputs; valids gated by flush so no handshake completes that cycle
  always_comb begin
    in_ready_o       = (r_state == S_IDLE);
    out_valid_o      = (r_state == S_RESP) & ~r_out_done & ~flush_i;
    redirect_valid_o = (r_state == S_RESP) & ~r_rd_done & ~flush_i;
    flush_o          = redirect_valid_o & redirect_ready_i;
  end

  // Held op; cleared on return to IDLE so the comparator sees zeros while idle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc <= '0; r_imm <= '0; r_rs1 <= '0; r_rs2 <= '0; r_op <= '0; r_f3 <= '0;
    end else if (r_state == S_IDLE && in_valid_i && !flush_i) begin
      r_pc <= in_pc_i; r_imm <= in_imm_i; r_rs1 <= in_rs1_i; r_rs2 <= in_rs2_i;
      r_op <= in_op_i; r_f3 <= in_funct3_i;
    end else if (r_state != S_IDLE && w_next == S_IDLE) begin
      r_pc <= '0; r_imm <= '0; r_rs1 <= '0; r_rs2 <= '0; r_op <= '0; r_f3 <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_taken <= 1'b0; r_exc <= 1'b0; r_target <= '0; r_link <= '0;
    end else if (r_state == S_EVAL && !flush_i) begin
      r_taken  <= w_taken;
      r_exc    <= w_exc;
      r_target <= w_target;
      r_link   <= r_pc + 32'd4;
    end
  end

  // Done flags; a channel with nothing to send starts out already done
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_out_done <= 1'b0; r_rd_done <= 1'b0;
    end else if (flush_i) begin
      r_out_done <= 1'b0; r_rd_done <= 1'b0;
    end else if (r_state == S_EVAL) begin
      r_out_done <= 1'b0;
      r_rd_done  <= ~(w_taken & ~w_exc);
    end else if (r_state == S_RESP && !w_both_done) begin
      r_out_done <= r_out_done | w_out_fire;
      r_rd_done  <= r_rd_done | w_rd_fire;
    end else begin
      r_out_done <= 1'b0; r_rd_done <= 1'b0;
    end
  end

  always_comb begin
    cmp_fn_o = 3'b111;
    case (r_f3)
      3'b000: cmp_fn_o = 3'b000;
      3'b001: cmp_fn_o = 3'b001;
      3'b100: cmp_fn_o = 3'b011;
      3'b101: cmp_fn_o = 3'b010;
      3'b110: cmp_fn_o = 3'b101;
      3'b111: cmp_fn_o = 3'b110;
      default: cmp_fn_o = 3'b111;
    endcase
  end

  assign cmp_a_o       = r_rs1;
  assign cmp_b_o       = r_rs2;
  assign redirect_pc_o = r_target;
  assign out_link_o    = r_link;
  assign out_taken_o   = r_taken;
  assign out_exc_o     = r_exc;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a scoreboard of expected resolutions.
module tb_branch_resolve_unit;
  logic        clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_rs2 = '0;
  logic [1:0]  in_op = '0;
  logic [2:0]  in_f3 = '0;
  logic [31:0] cmp_a, cmp_b, redirect_pc, out_link;
  logic [2:0]  cmp_fn;
  logic        cmp_result, redirect_valid, redirect_ready = 1'b0, flush_o;
  logic        out_valid, out_ready = 1'b0, out_taken, out_exc;

  int checks = 0, failures = 0;

  typedef struct {
    logic        taken, exc, redir;
    logic [31:0] link, tgt;
    logic [2:0]  fn;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared comparator
  function automatic logic tb_cmp(logic [2:0] fn, logic [31:0] a, logic [31:0] b);
    case (fn)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b011: return $signed(a) <  $signed(b);
      3'b010: return $signed(a) >= $signed(b);
      3'b101: return a <  b;
      3'b110: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
  assign cmp_result = tb_cmp(cmp_fn, cmp_a, cmp_b);

  branch_resolve_unit dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_pc_i(in_pc), .in_imm_i(in_imm), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
    .in_op_i(in_op), .in_funct3_i(in_f3),
    .cmp_a_o(cmp_a), .cmp_b_o(cmp_b), .cmp_fn_o(cmp_fn), .cmp_result_i(cmp_result),
    .redirect_valid_o(redirect_valid), .redirect_ready_i(redirect_ready),
    .redirect_pc_o(redirect_pc), .flush_o(flush_o),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_link_o(out_link), .out_taken_o(out_taken), .out_exc_o(out_exc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(logic [1:0] op, logic [2:0] f3, logic [31:0] pc,
                                 logic [31:0] imm, logic [31:0] rs1, logic [31:0] rs2);
    exp_t e;
    e.taken = 1'b0;
    if (op == 2'b00) begin
      case (f3)
        3'b000: e.taken = (rs1 == rs2);
        3'b001: e.taken = (rs1 != rs2);
        3'b100: e.taken = ($signed(rs1) < $signed(rs2));
        3'b101: e.taken = ($signed(rs1) >= $signed(rs2));
        3'b110: e.taken = (rs1 < rs2);
        3'b111: e.taken = (rs1 >= rs2);
        default: e.taken = 1'b0;
      endcase
    end else if (op != 2'b11) e.taken = 1'b1;
    e.tgt   = (op == 2'b10) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    e.exc   = e.taken & e.tgt[1];
    e.redir = e.taken & ~e.exc;
    e.link  = pc + 32'd4;
    case (f3)
      3'b000: e.fn = 3'b000;  3'b001: e.fn = 3'b001;
      3'b100: e.fn = 3'b011;  3'b101: e.fn = 3'b010;
      3'b110: e.fn = 3'b101;  3'b111: e.fn = 3'b110;
      default: e.fn = 3'b111;
    endcase
    return e;
  endfunction

  task automatic accept(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_f3 = f3; in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2;
    #1 chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // od/rd: cycles into RESP before out_ready / redirect_ready rise
  task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic [31:0] rs2, input int od, input int rd, input int exp_lat);
    exp_t e, p;
    int got_out = 0, got_rd = 0, lat = -1;
    logic hold_r = 1'b0;
    logic [31:0] rpc_hold = '0;
    e = model(op, f3, pc, imm, rs1, rs2);
    sb.push_back(e);
    accept(op, f3, pc, imm, rs1, rs2);
    #1;
    chk({name, "_eval_ready"}, in_ready, 0);
    chk({name, "_eval_outv"}, out_valid, 0);
    chk({name, "_cmp_fn"}, cmp_fn, e.fn);
    chk({name, "_cmp_a"}, cmp_a, rs1);
    chk({name, "_cmp_b"}, cmp_b, rs2);
    @(posedge clk);
    for (int c = 0; c < 30; c++) begin
      #1;
      out_ready = (c >= od);
      redirect_ready = (c >= rd);
      #1;
      if (in_ready) begin lat = c; break; end
      if (out_valid && out_ready) begin
        p = sb.pop_front();
        chk({name, "_taken"}, out_taken, p.taken);
        chk({name, "_exc"}, out_exc, p.exc);
        chk({name, "_link"}, out_link, p.link);
        got_out++;
      end
      if (redirect_valid) begin
        chk({name, "_redir_allowed"}, 1, e.redir);
        if (hold_r) chk({name, "_rpc_stable"}, redirect_pc, rpc_hold);
        hold_r = 1'b1; rpc_hold = redirect_pc;
        if (redirect_ready) begin
          chk({name, "_rpc"}, redirect_pc, e.tgt);
          chk({name, "_flush_o"}, flush_o, 1);
          got_rd++;
        end
      end else chk({name, "_flush_o_idle"}, flush_o, 0);
      @(posedge clk);
    end
    chk({name, "_done"}, (lat >= 0), 1);
    if (exp_lat >= 0) chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_out_cnt"}, got_out, 1);
    chk({name, "_rd_cnt"}, got_rd, e.redir);
    out_ready = 1'b0; redirect_ready = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_outv", out_valid, 0);
    chk("rst_rdv", redirect_valid, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_fn", cmp_fn, 0);
    chk("rst_cmp_a", cmp_a, 0);
    chk("rst_link", out_link, 0);
    chk("rst_rpc", redirect_pc, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_op("beq",   2'b00, 3'b000, 32'h8000_0000, 32'h10, 32'h1234, 32'h1234, 0, 0, 1);
    run_op("blt",   2'b00, 3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 0, 0, 1);
    run_op("bltu",  2'b00, 3'b110, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 0, 0, 1);
    run_op("jalrx", 2'b10, 3'b000, 32'h400, 32'h0, 32'h8000_0103, 32'h0, 0, 0, 1);
    run_op("jalr",  2'b10, 3'b000, 32'h400, 32'h0, 32'h8000_0101, 32'h0, 0, 0, 1);
    run_op("jalbp", 2'b01, 3'b000, 32'h2000, 32'h40, 32'h0, 32'h0, 0, 3, 4);
    run_op("outbp", 2'b01, 3'b000, 32'h2000, 32'hFFFF_FFF0, 32'h0, 32'h0, 2, 0, 3);
    run_op("wrap",  2'b01, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0, 0, 0, 1);
    run_op("rsvd",  2'b11, 3'b000, 32'h500, 32'h8, 32'h5, 32'h5, 0, 0, 1);
    run_op("f3_010", 2'b00, 3'b010, 32'h600, 32'h8, 32'h7, 32'h7, 0, 0, 1);
    run_op("bne",   2'b00, 3'b001, 32'h700, 32'h4, 32'h7, 32'h7, 0, 0, 1);
    run_op("bge",   2'b00, 3'b101, 32'h700, 32'hC, 32'h1, 32'hFFFF_FFFF, 0, 0, 1);
    run_op("bgeu",  2'b00, 3'b111, 32'h700, 32'h8, 32'h1, 32'hFFFF_FFFF, 0, 0, 1);

    // flush during EVAL
    accept(2'b01, 3'b000, 32'h3000, 32'h10, 32'h0, 32'h0);
    flush_i = 1'b1; out_ready = 1'b1; redirect_ready = 1'b1;
    #1;
    chk("fl_eval_outv", out_valid, 0);
    chk("fl_eval_flush_o", flush_o, 0);
    @(posedge clk); #1 flush_i = 1'b0;
    chk("fl_eval_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("fl_eval_quiet", out_valid | redirect_valid, 0);

    // flush during RESP
    out_ready = 1'b0; redirect_ready = 1'b0;
    accept(2'b01, 3'b000, 32'h3000, 32'h10, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("fl_resp_pre_outv", out_valid, 1);
    flush_i = 1'b1; out_ready = 1'b1; redirect_ready = 1'b1;
    #1;
    chk("fl_resp_outv", out_valid, 0);
    chk("fl_resp_rdv", redirect_valid, 0);
    chk("fl_resp_flush_o", flush_o, 0);
    @(posedge clk); #1 flush_i = 1'b0;
    chk("fl_resp_ready", in_ready, 1);
    chk("fl_resp_after", out_valid, 0);
    out_ready = 1'b0; redirect_ready = 1'b0;

    // async reset during RESP
    accept(2'b01, 3'b000, 32'h3000, 32'h10, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("ar_pre_rdv", redirect_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_ready", in_ready, 1);
    chk("ar_outv", out_valid, 0);
    chk("ar_rdv", redirect_valid, 0);
    chk("ar_taken", out_taken, 0);
    chk("ar_link", out_link, 0);
    chk("ar_rpc", redirect_pc, 0);
    chk("ar_cmp_a", cmp_a, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_op("post_rst", 2'b01, 3'b000, 32'h10, 32'h20, 32'h0, 32'h0, 0, 0, 1);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolution for the single-issue RV32 core. Accepts one branch/jump micro-op at a time over a valid/ready handshake, drives the shared comparator's operand and function inputs, samples the 1-bit compare result, and computes target and link address. It then issues a redirect to the fetch unit on a taken branch or jump and hands the resolved op downstream over a second valid/ready handshake. Fetch predicts not-taken, so every taken control transfer is a redirect.

## Interface
- No parameters; XLEN fixed at 32.
- clk_i  in  1  clock; all state on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- flush_i  in  1  pipeline flush from commit; kills any held op
- in_valid_i  in  1  micro-op valid
- in_ready_o  out  1  block can accept
- in_pc_i  in  32  op PC
- in_imm_i  in  32  sign-extended immediate
- in_rs1_i, in_rs2_i  in  32  source operand values
- in_op_i  in  2  00 branch, 01 JAL, 10 JALR, 11 reserved (treated as not-taken branch)
- in_funct3_i  in  3  RV32 branch funct3
- cmp_a_o, cmp_b_o  out  32  comparator operands (held rs1/rs2)
- cmp_fn_o  out  3  comparator function code
- cmp_result_i  in  1  comparator outcome, combinational from cmp_*_o
- redirect_valid_o  out  1  redirect request to fetch
- redirect_ready_i  in  1  fetch accepts redirect
- redirect_pc_o  out  32  redirect target
- flush_o  out  1  younger-op kill, = redirect_valid_o & redirect_ready_i
- out_valid_o  out  1  resolved op valid
- out_ready_i  in  1  downstream accepts
- out_link_o  out  32  PC+4 (writeback value for JAL/JALR)
- out_taken_o  out  1  op was taken
- out_exc_o  out  1  taken target misaligned (target[1]=1)

## Operation
- States: IDLE, EVAL, RESP. in_ready_o = (state==IDLE).
- IDLE: on in_valid_i, latch pc, imm, rs1, rs2, op, funct3 → EVAL.
- funct3→cmp_fn_o: BEQ 000→000, BNE 001→001, BLT 100→011, BGE 101→010, BLTU 110→101, BGEU 111→110; funct3 010/011 → fn 111 (constant 0, never taken). Driven from held register in every state; 000 with zero operands in IDLE.
- EVAL (one cycle): taken = cmp_result_i for branch, 1 for JAL/JALR, 0 for reserved. target = pc+imm (branch/JAL), (rs1+imm)&~1 (JALR); 32-bit wrap-around, carry discarded. exc = taken & target[1]. Register taken, target, exc, link=pc+4 (wraps) → RESP.
- RESP: out_valid_o=1 until out_ready_i sampled high. redirect_valid_o=1 iff taken & !exc, until redirect_ready_i sampled high. Each channel has a done flag; both may complete in the same cycle or in either order. Both done → IDLE.
- Outputs and redirect_pc_o stable while their valid is high and not accepted.
- flush_i: highest priority in any state; next state IDLE, done flags cleared, no handshake completes that cycle (redirect_valid_o and out_valid_o gated low while flush_i=1, so flush_o=0).
- Reserved op: completes normally with taken=0, exc=0.

## Timing
- Reset: state IDLE; in_ready_o=1; out_valid_o=0, redirect_valid_o=0, flush_o=0; out_taken_o=0, out_exc_o=0, out_link_o=0, redirect_pc_o=0; cmp_a_o=cmp_b_o=0, cmp_fn_o=000.
- Accept at edge N; EVAL cycle N+1; out_valid_o and redirect_valid_o high from cycle N+2.
- Best case throughput: one op per 3 cycles (accept, EVAL, RESP with both readys high).
- Reset assertion mid-op returns to reset values immediately (asynchronous); no partial handshake survives.
- No combinational path from in_valid_i to any output; in_ready_o depends only on state.

## Test plan
- BEQ rs1=rs2=0x1234, pc=0x8000_0000, imm=0x10, both readys high → redirect_pc_o=0x8000_0010, out_taken_o=1, out_link_o=0x8000_0004, flush_o one cycle, back to IDLE at N+3.
- BLT vs BLTU with rs1=0xFFFF_FFFF, rs2=1 → BLT taken (cmp_fn_o=011), BLTU not taken (cmp_fn_o=101), no redirect for BLTU.
- JALR rs1=0x8000_0103, imm=0 → target 0x8000_0102, out_exc_o=1, redirect_valid_o never asserts; JALR rs1=0x8000_0101 → target 0x8000_0100, redirect issued.
- Backpressure: JAL taken, redirect_ready_i low 3 cycles while out_ready_i high at first RESP cycle → out completes first, redirect_pc_o stable, IDLE only after redirect accepted.
- Wrap: pc=0xFFFF_FFFC, JAL imm=8 → target 0x0000_0004, link 0x0000_0000.
- flush_i in EVAL and again in RESP with readys high → no out or redirect handshake, flush_o=0, in_ready_o=1 next cycle; rst_n_i low in RESP → all outputs at reset values immediately.
